fetch_pc_queue: RTL and testbench
=================================

// Module: fetch_pc_queue
// PURPOSE
// - Parametrised next-generation instruction-fetch front end: PC generator plus an in-order prefetch queue.
// - Issues word-aligned fetch requests with a valid/ready handshake and queues the returned instructions.
// - Presents {pc, instr, next_pc} to decode with a valid/ready handshake.
// - Handles branch redirect and interrupt-vector redirect. Responses already in flight at a redirect are discarded.
// - Sits between the instruction memory/cache port and the IF/ID stage.
// PARAMETERS
// XLEN        32  PC/address/instruction width
// DEPTH       4   prefetch queue entries; also the cap on (queued + outstanding) fetches; power of 2, >=2
// ISR_SHIFT   3   log2 bytes per ISR vector slot; vector = mtvec + (device_id << ISR_SHIFT)
// DEV_W       6   device_id width
// RESET_PC    0   PC after reset
// PORTS
// clk            in   1      clock, rising edge
// rst_n          in   1      asynchronous active-low reset
// mem_req_valid  out  1      fetch request valid
// mem_req_ready  in   1      memory accepts request
// mem_req_addr   out  XLEN   fetch address, bits[1:0]=0
// mem_rsp_valid  in   1      instruction returned (in order, 1 per accepted req, >=1 cycle after accept)
// mem_rsp_data   in   XLEN   returned instruction
// redirect       in   1      branch/jump taken (1-cycle pulse)
// redirect_addr  in   XLEN   branch target
// irq_req        in   1      interrupt request (level, held until irq_ack)
// csr_mtvec      in   XLEN   trap vector base
// device_id      in   DEV_W  interrupting device index
// irq_ack        out  1      1-cycle pulse: vector redirect taken
// out_valid      out  1      queue head valid
// out_ready      in   1      decode accepts head
// out_pc         out  XLEN   PC of head instruction
// out_instr      out  XLEN   head instruction
// out_next_pc    out  XLEN   out_pc + 4
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - fetch_pc=RESET_PC; queue empty; outstanding=0; drop=0.
//   - Outputs: mem_req_valid=0, irq_ack=0, out_valid=0, mem_req_addr=RESET_PC, out_pc=0, out_instr=0, out_next_pc=4.
//   - Reset mid-operation abandons all in-flight state. The memory side must also reset.
// - Request issue:
//   - mem_req_valid = (queued + outstanding < DEPTH) && !redirect && !take_irq.
//   - On accept (valid && ready): fetch_pc += 4, wrapping modulo 2^XLEN; outstanding++.
//   - mem_req_valid/mem_req_addr stay stable until accepted unless a redirect occurs.
// - Response:
//   - mem_rsp_valid is always accepted; space is reserved at issue, so overflow is impossible.
//   - If drop>0: the response is discarded and drop--.
//   - Else: push {rsp_pc, data}, where rsp_pc tracks the PC of the oldest outstanding request.
//   - outstanding-- in either case.
// - Output: out_valid = queue not empty. Pop on out_valid && out_ready. Push and pop may occur in the same cycle.
//   - Full queue (DEPTH entries) blocks new requests only; out side unaffected.
// - Redirect (branch):
//   - Same cycle: flush queue (out_valid=0 next cycle); drop += outstanding, excluding a response arriving that cycle; outstanding=0.
//   - Next cycle: fetch_pc=redirect_addr & ~3 and mem_req_valid=1, giving 1-cycle redirect-to-request latency.
//   - A request offered in the redirect cycle is not issued.
// - Interrupt: take_irq = irq_req && !redirect.
//   - Same flush/drop as redirect, with fetch_pc = (csr_mtvec + (device_id << ISR_SHIFT)) & ~3, truncated to XLEN.
//   - irq_ack=1 for exactly that cycle.
//   - Simultaneous redirect and irq_req: redirect wins; irq stays pending and is taken the next cycle that has no redirect.
// - Pop in a flush cycle is allowed; the popped entry is the last one delivered.
// - New responses during drop>0 never reach the queue, even if a new request was accepted after the flush.
// - No combinational path from mem_rsp_* to out_*; queue adds 1 cycle (rsp at N -> out_valid at N+1).
// TESTING
// 1. Reset, ready=1, rsp 1 cycle after accept, out_ready=1 -> addrs 0,4,8,...; out_pc=0 with instr, out_next_pc=4; steady 1 instr/cycle.
// 2. out_ready=0, DEPTH=4 -> exactly 4 requests accepted, then mem_req_valid=0; release -> 4 pops in order, issue resumes.
// 3. 2 outstanding, redirect to 0x103 -> next cycle mem_req_addr=0x100; 2 stale rsps dropped; first out_pc=0x100.
// 4. irq_req, mtvec=0x800, device_id=5 -> irq_ack 1 cycle, next mem_req_addr=0x828; irq+redirect same cycle -> branch target first, 0x828 the cycle after.
// 5. Redirect to 0xFFFFFFFC -> addrs 0xFFFFFFFC then 0x0 (wrap); out_next_pc of first=0x0.
// 6. rst_n low mid-burst with outstanding=3 -> all outputs at reset values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_queue_if.sv
// Fetch front-end bundle: memory request/response, redirect/interrupt, decode side.
// The master modport belongs to the fetch unit; the slave modport belongs to its environment
// (instruction memory, branch unit, interrupt controller and decode).
interface fetch_pc_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEV_W = 6
);
  // memory request / response
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_data;
  // control-flow changes
  logic              redirect;
  logic [XLEN-1:0]   redirect_addr;
  logic              irq_req;
  logic [XLEN-1:0]   csr_mtvec;
  logic [DEV_W-1:0]  device_id;
  logic              irq_ack;
  // decode side
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_instr;
  logic [XLEN-1:0]   out_next_pc;

  modport master (
    output mem_req_valid, mem_req_addr, irq_ack,
    output out_valid, out_pc, out_instr, out_next_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  redirect, redirect_addr, irq_req, csr_mtvec, device_id,
    input  out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, irq_ack,
    input  out_valid, out_pc, out_instr, out_next_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output redirect, redirect_addr, irq_req, csr_mtvec, device_id,
    output out_ready
  );
endinterface

// File: rtl/fetch_pc_queue.sv
// Purpose: PC generator plus in-order prefetch queue feeding decode, with branch/interrupt redirect.
// Latency: redirect -> new request 1 cycle; memory response -> out_valid 1 cycle.
// Backpressure: queued + outstanding fetches capped at DEPTH; a stalled decode only stops new requests.
module fetch_pc_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              ISR_SHIFT = 3,
  parameter int              DEV_W     = 6,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input logic             clk,
  input logic             rst_n,
  fetch_pc_queue_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // Stale responses can pile up across back-to-back redirects while memory is slow,
  // so the discard counter gets headroom beyond a single queue's worth.
  localparam int DROP_W = CNT_W + 4;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  // architectural state
  logic [XLEN-1:0]   fetch_pc;   // address of the next request to issue
  logic [XLEN-1:0]   rsp_pc;     // address of the oldest live outstanding request
  logic [CNT_W-1:0]  outst;      // live requests accepted but not yet answered
  logic [DROP_W-1:0] drop;       // responses still to be discarded after a flush
  logic [CNT_W-1:0]  q_cnt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  entry_t            q_mem [DEPTH];

  // per-cycle decisions
  logic              take_irq;
  logic              flush;
  logic [CNT_W:0]    inflight;
  logic              req_vld;
  logic              req_acc;
  logic              rsp_drop;
  logic              rsp_keep;
  logic              push;
  logic              pop;
  logic              head_vld;
  logic [XLEN-1:0]   vec_addr;
  logic [XLEN-1:0]   tgt_raw;
  logic [XLEN-1:0]   tgt_pc;
  entry_t            head;
  entry_t            wr_ent;

  // Decide issue, redirect and queue movements for this cycle. rst_n gates the
  // combinational outputs so they sit at their reset values while reset is held.
  always_comb begin
    take_irq = rst_n && bus.irq_req && !bus.redirect;
    flush    = bus.redirect || take_irq;
    inflight = {1'b0, q_cnt} + {1'b0, outst};
    req_vld  = rst_n && (inflight < DEPTH_C) && !flush;
    req_acc  = req_vld && bus.mem_req_ready;
    rsp_drop = bus.mem_rsp_valid && (drop != '0);
    rsp_keep = bus.mem_rsp_valid && (drop == '0);
    // A response landing in a flush cycle belongs to the old path.
    push     = rsp_keep && !flush;
    head_vld = (q_cnt != '0);
    pop      = head_vld && bus.out_ready;
    vec_addr = bus.csr_mtvec + (XLEN'(bus.device_id) << ISR_SHIFT);
    tgt_raw  = bus.redirect ? bus.redirect_addr : vec_addr;
    tgt_pc   = {tgt_raw[XLEN-1:2], 2'b00};
    head     = q_mem[rd_ptr];
    wr_ent.pc    = rsp_pc;
    wr_ent.instr = bus.mem_rsp_data;
  end

  // Fetch PC: redirect beats interrupt beats sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (flush) begin
      fetch_pc <= tgt_pc;
    end else if (req_acc) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // PC tag for returning instructions; restarts at the new target on a flush
  // because every older response will be discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pc <= RESET_PC;
    end else if (flush) begin
      rsp_pc <= tgt_pc;
    end else if (push) begin
      rsp_pc <= rsp_pc + XLEN'(4);
    end
  end

  // Live outstanding count and stale-response discard count. On a flush all
  // requests still in flight (minus one answered this cycle) become stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
      drop  <= '0;
    end else if (flush) begin
      outst <= '0;
      drop  <= drop + DROP_W'(outst) - DROP_W'(bus.mem_rsp_valid);
    end else begin
      outst <= outst + CNT_W'(req_acc) - CNT_W'(rsp_keep);
      if (rsp_drop) begin
        drop <= drop - DROP_W'(1);
      end
    end
  end

  // Queue pointers and occupancy; a flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      q_cnt  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      q_cnt <= q_cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Queue storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= wr_ent;
    end
  end

  assign bus.mem_req_valid = req_vld;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.irq_ack       = take_irq;
  assign bus.out_valid     = head_vld;
  assign bus.out_pc        = head_vld ? head.pc    : '0;
  assign bus.out_instr     = head_vld ? head.instr : '0;
  assign bus.out_next_pc   = bus.out_pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Randomised and directed bench for fetch_pc_queue against a queue-level model.
// The model keeps the list of in-flight requests (tagged stale on redirect) and the decode queue.
module tb_fetch_pc_queue;
  localparam int          XLEN      = 32;
  localparam int          DEPTH     = 4;
  localparam int          ISR_SHIFT = 3;
  localparam int          DEV_W     = 6;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_queue_if #(.XLEN(XLEN), .DEV_W(DEV_W)) bus ();

  fetch_pc_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ISR_SHIFT(ISR_SHIFT), .DEV_W(DEV_W), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        infl[$];
  ent_t        oq[$];
  logic [31:0] m_pc;
  bit          irq_pend;
  logic [31:0] mtvec;
  logic [5:0]  devid;
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_idle();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus.irq_req       = 1'b0;
    bus.csr_mtvec     = '0;
    bus.device_id     = '0;
    bus.out_ready     = 1'b0;
  endtask

  // Asynchronous reset from wherever we are; memory in-flight state is abandoned too.
  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    infl.delete();
    oq.delete();
    m_pc     = RESET_PC;
    irq_pend = 1'b0;
    mtvec    = '0;
    devid    = '0;
    #1;
    chk1("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk1("rst_irq_ack", bus.irq_ack, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_req_addr", bus.mem_req_addr, RESET_PC);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_next_pc", bus.out_next_pc, 32'h4);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs at the falling edge, compare 1 time unit later,
  // then advance the model by what the next rising edge must do.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] raddr,
                      input bit ordy, input int rsp_pct);
    bit          rsp, take, exp_vld, pop, acc, flush;
    int          live;
    logic [31:0] vec, tgt;
    req_t        r;
    ent_t        e;
    @(negedge clk);
    rsp = (infl.size() > 0) && (infl[0].cyc < cyc) && ($urandom_range(99) < rsp_pct);
    bus.mem_req_ready = rdy;
    bus.redirect      = redir;
    bus.redirect_addr = raddr;
    bus.out_ready     = ordy;
    bus.irq_req       = irq_pend;
    bus.csr_mtvec     = mtvec;
    bus.device_id     = devid;
    bus.mem_rsp_valid = rsp;
    bus.mem_rsp_data  = rsp ? infl[0].data : $urandom();
    #1;
    take = irq_pend && !redir;
    live = 0;
    foreach (infl[i]) if (!infl[i].stale) live++;
    exp_vld = ((oq.size() + live) < DEPTH) && !redir && !take;
    chk1("req_valid", bus.mem_req_valid, exp_vld);
    if (exp_vld) chk("req_addr", bus.mem_req_addr, m_pc);
    chk1("irq_ack", bus.irq_ack, take);
    chk1("out_valid", bus.out_valid, oq.size() > 0);
    if (oq.size() > 0) begin
      chk("out_pc", bus.out_pc, oq[0].pc);
      chk("out_instr", bus.out_instr, oq[0].instr);
      chk("out_next_pc", bus.out_next_pc, oq[0].pc + 32'd4);
    end
    pop   = (oq.size() > 0) && ordy;
    acc   = exp_vld && rdy;
    flush = redir || take;
    if (pop) void'(oq.pop_front());
    if (rsp) begin
      r = infl.pop_front();
      if (!r.stale && !flush) begin
        e.pc    = r.addr;
        e.instr = r.data;
        oq.push_back(e);
      end
    end
    if (flush) begin
      oq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      vec  = mtvec + (32'(devid) << ISR_SHIFT);
      tgt  = redir ? raddr : vec;
      m_pc = tgt & 32'hFFFF_FFFC;
    end else if (acc) begin
      r.addr  = m_pc;
      r.data  = $urandom();
      r.cyc   = cyc;
      r.stale = 1'b0;
      infl.push_back(r);
      m_pc = m_pc + 32'd4;
    end
    if (take) irq_pend = 1'b0;
    cyc++;
  endtask

  initial begin
    int          n;
    bit          found;
    bit          redir;
    logic [31:0] ra;

    // Streaming with one-cycle memory: sequential addresses, one instruction per cycle.
    apply_reset();
    step(1, 0, 0, 1, 100); chk("t1_addr0", bus.mem_req_addr, 32'h0);
    step(1, 0, 0, 1, 100); chk("t1_addr1", bus.mem_req_addr, 32'h4);
    step(1, 0, 0, 1, 100);
    chk1("t1_first_vld", bus.out_valid, 1'b1);
    chk("t1_first_pc", bus.out_pc, 32'h0);
    chk("t1_first_next", bus.out_next_pc, 32'h4);
    for (int k = 3; k < 10; k++) begin
      step(1, 0, 0, 1, 100);
      chk("t1_stream_pc", bus.out_pc, 32'(4 * (k - 2)));
    end

    // Decode stalled: exactly DEPTH requests go out, then issue stops until pops free space.
    apply_reset();
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 0, 100);
      if (bus.mem_req_valid) n++;
    end
    chk("t2_accepts", 32'(n), 32'd4);
    chk1("t2_stalled", bus.mem_req_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 1, 100);
      chk("t2_pop_pc", bus.out_pc, 32'(4 * k));
      if (k == 1) begin
        chk1("t2_resume_vld", bus.mem_req_valid, 1'b1);
        chk("t2_resume_addr", bus.mem_req_addr, 32'h10);
      end
    end

    // Branch with two stale requests in flight.
    apply_reset();
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 1, 32'h103, 1, 0); chk1("t3_redir_cycle", bus.mem_req_valid, 1'b0);
    step(1, 0, 0, 1, 100);
    chk1("t3_vld", bus.mem_req_valid, 1'b1);
    chk("t3_addr", bus.mem_req_addr, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 1, 100);
      if (!found && bus.out_valid) begin
        chk("t3_first_pc", bus.out_pc, 32'h100);
        found = 1'b1;
      end
    end
    chk1("t3_seen", found, 1'b1);

    // Interrupt vector, then interrupt colliding with a branch.
    apply_reset();
    mtvec = 32'h800; devid = 6'd5; irq_pend = 1'b1;
    step(1, 0, 0, 1, 100); chk1("t4_ack", bus.irq_ack, 1'b1);
    step(1, 0, 0, 1, 100);
    chk1("t4_ack_pulse", bus.irq_ack, 1'b0);
    chk("t4_vec_addr", bus.mem_req_addr, 32'h828);
    repeat (3) step(1, 0, 0, 1, 100);
    irq_pend = 1'b1;
    step(1, 1, 32'h200, 1, 100); chk1("t4_redir_wins", bus.irq_ack, 1'b0);
    step(1, 0, 0, 1, 100);
    chk1("t4_irq_next", bus.irq_ack, 1'b1);
    chk("t4_branch_first", bus.mem_req_addr, 32'h200);
    step(1, 0, 0, 1, 100);
    chk1("t4_vec_vld", bus.mem_req_valid, 1'b1);
    chk("t4_vec_after", bus.mem_req_addr, 32'h828);

    // Address wrap at the top of the address space.
    apply_reset();
    step(1, 0, 0, 1, 100);
    step(0, 1, 32'hFFFF_FFFC, 1, 100);
    step(1, 0, 0, 1, 100); chk("t5_top", bus.mem_req_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 1, 100); chk("t5_wrap", bus.mem_req_addr, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 1, 100);
      if (!found && bus.out_valid && bus.out_pc == 32'hFFFF_FFFC) begin
        chk("t5_next_pc", bus.out_next_pc, 32'h0);
        found = 1'b1;
      end
    end
    chk1("t5_seen", found, 1'b1);

    // Reset with three requests outstanding, then restart from RESET_PC.
    apply_reset();
    repeat (3) step(1, 0, 0, 1, 0);
    apply_reset();
    step(1, 0, 0, 1, 100);
    chk1("t6_restart_vld", bus.mem_req_valid, 1'b1);
    chk("t6_restart_addr", bus.mem_req_addr, RESET_PC);

    // Random traffic: stalls on both sides, variable memory latency, branches, interrupts, resets.
    apply_reset();
    for (int k = 0; k < 4000; k++) begin
      if (!irq_pend && $urandom_range(99) < 3) begin
        irq_pend = 1'b1;
        mtvec    = $urandom();
        devid    = 6'($urandom());
      end
      redir = ($urandom_range(99) < 6);
      case ($urandom_range(2))
        0: ra = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        1: ra = $urandom();
        default: ra = 32'($urandom_range(1023));
      endcase
      step($urandom_range(99) < 70, redir, ra, $urandom_range(99) < 60, 60);
      if ($urandom_range(999) < 3) apply_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
